// File: rtl/qsfp_i2c_cmd_arb_if.sv
// Requester and sequencer signal bundle for qsfp_i2c_cmd_arb.
// The slave modport is the arbiter's view; master is the requester/sequencer side.
interface qsfp_i2c_cmd_arb_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]   req_valid;
    logic [NUM_CH-1:0]   req_ready;
    logic [NUM_CH-1:0]   req_rw;
    logic [8*NUM_CH-1:0] req_id;
    logic [8*NUM_CH-1:0] req_addr;
    logic [8*NUM_CH-1:0] req_wdata;
    logic [NUM_CH-1:0]   rsp_valid;
    logic [7:0]          rsp_rdata;
    logic                rsp_err;
    logic                seq_pulse;
    logic                seq_rw;
    logic [7:0]          seq_id;
    logic [7:0]          seq_addr;
    logic [7:0]          seq_wdata;
    logic [7:0]          seq_rdata;
    logic                seq_cmplt;
    logic                busy;

    modport slave (
        input  req_valid, req_rw, req_id, req_addr, req_wdata, seq_rdata, seq_cmplt,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output seq_pulse, seq_rw, seq_id, seq_addr, seq_wdata, busy
    );

    modport master (
        output req_valid, req_rw, req_id, req_addr, req_wdata, seq_rdata, seq_cmplt,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  seq_pulse, seq_rw, seq_id, seq_addr, seq_wdata, busy
    );
endinterface

// File: rtl/qsfp_i2c_cmd_arb.sv
// Round-robin N-channel arbiter in front of the byte-level I2C sequencer; prepends a
// channel-mux select write and bounds every command with a completion timeout.
// Define QSFP_I2C_ARB_MUX_CACHE_EN to skip the select write when the mux already points at the channel.
module qsfp_i2c_cmd_arb #(
    parameter int         NUM_CH      = 4,
    parameter logic [7:0] MUX_ID      = 8'hE0,
    parameter int         TIMEOUT_CYC = 2000000
) (
    input  logic              sys_if_clk,
    input  logic              sys_if_rstn,
    qsfp_i2c_cmd_arb_if.slave bus
);
    localparam int            PW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int            CW       = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MUX_ISSUE = 3'd1,
        ST_MUX_WAIT  = 3'd2,
        ST_CMD_ISSUE = 3'd3,
        ST_CMD_WAIT  = 3'd4,
        ST_RESP      = 3'd5
    } state_t;

    state_t            state_r, state_nx;
    logic [PW-1:0]     rr_ptr_r, win_idx_s, ch_r;
    logic              win_vld_s, hit_s, to_exp_s, accept_s;
    logic              rw_r;
    logic [7:0]        id_r, addr_r, wdata_r;
    logic [CW-1:0]     cnt_r;
    logic [NUM_CH-1:0] req_ready_s, ch_onehot_s, rsp_valid_r;
    logic              seq_ld_s, seq_rw_nx, seq_pulse_r, seq_rw_r;
    logic [7:0]        seq_id_nx, seq_addr_nx, seq_wdata_nx;
    logic [7:0]        seq_id_r, seq_addr_r, seq_wdata_r;
    logic              rsp_ld_s, rsp_err_nx, rsp_err_r;
    logic [7:0]        rsp_rdata_nx, rsp_rdata_r;
    logic              busy_r;

    // First valid channel at or after rr_ptr_r; reverse scan lets the nearest one win
    always_comb begin
        win_idx_s = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            win_idx_s = bus.req_valid[PW'((32'(rr_ptr_r) + i) % NUM_CH)] ?
                        PW'((32'(rr_ptr_r) + i) % NUM_CH) : win_idx_s;
        end
    end

    // One-hot decode of the channel currently being served
    always_comb begin
        ch_onehot_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_onehot_s[c] = (ch_r == PW'(c));
        end
    end

    assign win_vld_s = sys_if_rstn && (|bus.req_valid);
    assign to_exp_s  = (cnt_r >= TO_LAST);
    assign accept_s  = |req_ready_s;

`ifdef QSFP_I2C_ARB_MUX_CACHE_EN
    logic          cache_vld_r;
    logic [PW-1:0] cache_ch_r;

    // Mux cache: filled by a completed select write, dropped on any timeout
    always_ff @(posedge sys_if_clk) begin
        if (!sys_if_rstn) begin
            cache_vld_r <= 1'b0;
            cache_ch_r  <= '0;
        end else if ((state_r == ST_MUX_WAIT) && bus.seq_cmplt) begin
            cache_vld_r <= 1'b1;
            cache_ch_r  <= ch_r;
        end else if (((state_r == ST_MUX_WAIT) || (state_r == ST_CMD_WAIT)) && to_exp_s) begin
            cache_vld_r <= 1'b0;
            cache_ch_r  <= cache_ch_r;
        end else begin
            cache_vld_r <= cache_vld_r;
            cache_ch_r  <= cache_ch_r;
        end
    end

    assign hit_s = cache_vld_r && (cache_ch_r == win_idx_s);
`else
    assign hit_s = 1'b0;
`endif

    // Next-state, grant and register-load decode
    always_comb begin
        state_nx     = state_r;
        req_ready_s  = '0;
        seq_ld_s     = 1'b0;
        seq_rw_nx    = 1'b0;
        seq_id_nx    = 8'h00;
        seq_addr_nx  = 8'h00;
        seq_wdata_nx = 8'h00;
        rsp_ld_s     = 1'b0;
        rsp_err_nx   = 1'b0;
        rsp_rdata_nx = 8'h00;
        case (state_r)
            ST_IDLE: begin
                if (win_vld_s) begin
                    req_ready_s[win_idx_s] = 1'b1;
                    seq_ld_s = 1'b1;
                    if (hit_s) begin
                        state_nx     = ST_CMD_ISSUE;
                        seq_rw_nx    = bus.req_rw[win_idx_s];
                        seq_id_nx    = bus.req_id[{win_idx_s, 3'b000} +: 8];
                        seq_addr_nx  = bus.req_addr[{win_idx_s, 3'b000} +: 8];
                        seq_wdata_nx = bus.req_wdata[{win_idx_s, 3'b000} +: 8];
                    end else begin
                        state_nx     = ST_MUX_ISSUE;
                        seq_id_nx    = MUX_ID;
                        seq_wdata_nx = 8'h01 << win_idx_s;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_MUX_ISSUE: state_nx = ST_MUX_WAIT;
            ST_MUX_WAIT: begin
                if (bus.seq_cmplt) begin
                    state_nx     = ST_CMD_ISSUE;
                    seq_ld_s     = 1'b1;
                    seq_rw_nx    = rw_r;
                    seq_id_nx    = id_r;
                    seq_addr_nx  = addr_r;
                    seq_wdata_nx = wdata_r;
                end else if (to_exp_s) begin
                    state_nx   = ST_RESP;
                    rsp_ld_s   = 1'b1;
                    rsp_err_nx = 1'b1;
                end else begin
                    state_nx = ST_MUX_WAIT;
                end
            end
            ST_CMD_ISSUE: state_nx = ST_CMD_WAIT;
            ST_CMD_WAIT: begin
                if (bus.seq_cmplt) begin
                    state_nx     = ST_RESP;
                    rsp_ld_s     = 1'b1;
                    rsp_rdata_nx = bus.seq_rdata;
                end else if (to_exp_s) begin
                    state_nx   = ST_RESP;
                    rsp_ld_s   = 1'b1;
                    rsp_err_nx = 1'b1;
                end else begin
                    state_nx = ST_CMD_WAIT;
                end
            end
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge sys_if_clk) begin
        if (!sys_if_rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Capture the granted request and advance the round-robin pointer
    always_ff @(posedge sys_if_clk) begin
        if (!sys_if_rstn) begin
            rr_ptr_r <= '0;
            ch_r     <= '0;
            rw_r     <= 1'b0;
            id_r     <= 8'h00;
            addr_r   <= 8'h00;
            wdata_r  <= 8'h00;
        end else if (accept_s) begin
            rr_ptr_r <= PW'((32'(win_idx_s) + 1) % NUM_CH);
            ch_r     <= win_idx_s;
            rw_r     <= bus.req_rw[win_idx_s];
            id_r     <= bus.req_id[{win_idx_s, 3'b000} +: 8];
            addr_r   <= bus.req_addr[{win_idx_s, 3'b000} +: 8];
            wdata_r  <= bus.req_wdata[{win_idx_s, 3'b000} +: 8];
        end else begin
            rr_ptr_r <= rr_ptr_r;
            ch_r     <= ch_r;
            rw_r     <= rw_r;
            id_r     <= id_r;
            addr_r   <= addr_r;
            wdata_r  <= wdata_r;
        end
    end

    // Completion timer: cleared while issuing, saturating count while waiting
    always_ff @(posedge sys_if_clk) begin
        if (!sys_if_rstn) begin
            cnt_r <= '0;
        end else if ((state_r == ST_MUX_ISSUE) || (state_r == ST_CMD_ISSUE)) begin
            cnt_r <= '0;
        end else if ((state_r == ST_MUX_WAIT) || (state_r == ST_CMD_WAIT)) begin
            cnt_r <= (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Sequencer command outputs; fields hold until the next issue
    always_ff @(posedge sys_if_clk) begin
        if (!sys_if_rstn) begin
            seq_pulse_r <= 1'b0;
            seq_rw_r    <= 1'b0;
            seq_id_r    <= 8'h00;
            seq_addr_r  <= 8'h00;
            seq_wdata_r <= 8'h00;
        end else if (seq_ld_s) begin
            seq_pulse_r <= 1'b1;
            seq_rw_r    <= seq_rw_nx;
            seq_id_r    <= seq_id_nx;
            seq_addr_r  <= seq_addr_nx;
            seq_wdata_r <= seq_wdata_nx;
        end else begin
            seq_pulse_r <= 1'b0;
            seq_rw_r    <= seq_rw_r;
            seq_id_r    <= seq_id_r;
            seq_addr_r  <= seq_addr_r;
            seq_wdata_r <= seq_wdata_r;
        end
    end

    // Response outputs and busy flag
    always_ff @(posedge sys_if_clk) begin
        if (!sys_if_rstn) begin
            rsp_valid_r <= '0;
            rsp_rdata_r <= 8'h00;
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_ld_s ? ch_onehot_s : '0;
            rsp_rdata_r <= rsp_ld_s ? rsp_rdata_nx : rsp_rdata_r;
            rsp_err_r   <= rsp_ld_s ? rsp_err_nx : rsp_err_r;
            busy_r      <= (state_nx != ST_IDLE);
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.seq_pulse = seq_pulse_r;
    assign bus.seq_rw    = seq_rw_r;
    assign bus.seq_id    = seq_id_r;
    assign bus.seq_addr  = seq_addr_r;
    assign bus.seq_wdata = seq_wdata_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_qsfp_i2c_cmd_arb.sv
// Directed bench for qsfp_i2c_cmd_arb: 4 channels, 16-cycle timeout, hand-computed expectations.
module tb_qsfp_i2c_cmd_arb;
    localparam int NUM_CH      = 4;
    localparam int TIMEOUT_CYC = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   pass_cnt = 0;
    int   tot_cnt  = 0;
    int   fail_cnt = 0;

    qsfp_i2c_cmd_arb_if #(.NUM_CH(NUM_CH)) bus ();

    qsfp_i2c_cmd_arb #(
        .NUM_CH(NUM_CH),
        .MUX_ID(8'hE0),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .sys_if_clk(clk),
        .sys_if_rstn(rstn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] seq_now();
        return {6'd0, bus.seq_pulse, bus.seq_rw, bus.seq_id, bus.seq_addr, bus.seq_wdata};
    endfunction

    function automatic logic [31:0] cmd(input logic rw, input logic [7:0] id,
                                        input logic [7:0] addr, input logic [7:0] wdata);
        return {6'd0, 1'b1, rw, id, addr, wdata};
    endfunction

    function automatic logic [31:0] onehot(input int ch);
        logic [31:0] v;
        v = 32'd1 << ch;
        return v;
    endfunction

    task automatic set_req(input int ch, input logic rw, input logic [7:0] id,
                           input logic [7:0] addr, input logic [7:0] wdata);
        bus.req_valid[ch]        = 1'b1;
        bus.req_rw[ch]           = rw;
        bus.req_id[8*ch +: 8]    = id;
        bus.req_addr[8*ch +: 8]  = addr;
        bus.req_wdata[8*ch +: 8] = wdata;
    endtask

    // Check the combinational grant, then move to the cycle after acceptance.
    task automatic grant(input string tag, input int ch);
        #1;
        check({tag, "_ready"}, 32'(bus.req_ready), onehot(ch));
        tick();
        bus.req_valid[ch] = 1'b0;
    endtask

    // At the mux pulse cycle: check it, complete after lat cycles, land on the command pulse cycle.
    task automatic expect_mux(input string tag, input int ch, input int lat);
        logic [7:0] sel;
        sel = 8'h01 << ch;
        check({tag, "_mux"}, seq_now(), cmd(1'b0, 8'hE0, 8'h00, sel));
        tick_n(lat);
        bus.seq_cmplt = 1'b1;
        tick();
        bus.seq_cmplt = 1'b0;
    endtask

    task automatic finish_cmd(input string tag, input int ch, input int lat, input logic [7:0] rdata);
        tick_n(lat);
        bus.seq_cmplt = 1'b1;
        bus.seq_rdata = rdata;
        tick();
        bus.seq_cmplt = 1'b0;
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), onehot(ch));
        check({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'(rdata));
        check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        tick();
        check({tag, "_rsp_drop"}, {31'd0, bus.busy} | 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, "_rsp"}, {15'd0, bus.rsp_err, bus.rsp_rdata, 4'd0, bus.rsp_valid}, 32'd0);
        check({tag, "_seq"}, seq_now(), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_rw    = '0;
        bus.req_id    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.seq_rdata = 8'h00;
        bus.seq_cmplt = 1'b0;

        tick_n(3);
        check_reset_outputs("reset");
        rstn = 1'b1;
        tick();

        // Single read on channel 2, cold cache, 5-cycle sequencer latency
        set_req(2, 1'b1, 8'hA0, 8'h10, 8'h00);
        grant("t1", 2);
        check("t1_busy", 32'(bus.busy), 32'd1);
        expect_mux("t1", 2, 5);
        check("t1_cmd", seq_now(), cmd(1'b1, 8'hA0, 8'h10, 8'h00));
        tick();
        check("t1_pulse_drop", 32'(bus.seq_pulse), 32'd0);
        finish_cmd("t1", 2, 4, 8'hA5);

        // Second request on channel 2
        set_req(2, 1'b0, 8'hA0, 8'h20, 8'h5A);
        grant("t2", 2);
`ifndef QSFP_I2C_ARB_MUX_CACHE_EN
        expect_mux("t2", 2, 1);
`endif
        check("t2_cmd", seq_now(), cmd(1'b0, 8'hA0, 8'h20, 8'h5A));
        finish_cmd("t2", 2, 1, 8'h33);

        // All four channels pending from reset: round-robin 0,1,2,3
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            logic [7:0] cb;
            cb = 8'(c);
            set_req(c, cb[0], 8'h50 + cb, 8'h60 + cb, 8'h70 + cb);
        end
        for (int g = 0; g < NUM_CH; g++) begin
            logic [7:0] gb;
            gb = 8'(g);
            grant($sformatf("t3_ch%0d", g), g);
            expect_mux($sformatf("t3_ch%0d", g), g, 1);
            check($sformatf("t3_ch%0d_cmd", g), seq_now(), cmd(gb[0], 8'h50 + gb, 8'h60 + gb, 8'h70 + gb));
            finish_cmd($sformatf("t3_ch%0d", g), g, 2, 8'hC0 + gb);
        end

        // Timeout on channel 1 command, then late completion, then mux reissue
        set_req(1, 1'b0, 8'hB1, 8'h41, 8'h99);
        grant("t4", 1);
        expect_mux("t4", 1, 1);
        check("t4_cmd", seq_now(), cmd(1'b0, 8'hB1, 8'h41, 8'h99));
        bus.seq_rdata = 8'hEE;
        tick_n(TIMEOUT_CYC);
        check("t4_no_rsp_early", 32'(bus.rsp_valid), 32'd0);
        check("t4_busy_wait", 32'(bus.busy), 32'd1);
        tick();
        check("t4_to_valid", 32'(bus.rsp_valid), onehot(1));
        check("t4_to_err", 32'(bus.rsp_err), 32'd1);
        check("t4_to_rdata", 32'(bus.rsp_rdata), 32'd0);
        tick();
        check("t4_idle", {31'd0, bus.busy} | 32'(bus.rsp_valid), 32'd0);
        bus.seq_cmplt = 1'b1;
        tick();
        bus.seq_cmplt = 1'b0;
        check("t4_late_cmplt", {30'd0, bus.busy, bus.seq_pulse} | 32'(bus.rsp_valid), 32'd0);
        tick();
        check("t4_late_cmplt_rsp", 32'(bus.rsp_valid), 32'd0);
        set_req(1, 1'b1, 8'hB1, 8'h42, 8'h00);
        grant("t4b", 1);
        expect_mux("t4b", 1, 1);
        check("t4b_cmd", seq_now(), cmd(1'b1, 8'hB1, 8'h42, 8'h00));
        finish_cmd("t4b", 1, 2, 8'h77);

        // Completion on the expiry cycle wins
        set_req(1, 1'b1, 8'hB1, 8'h43, 8'h00);
        grant("t5", 1);
`ifndef QSFP_I2C_ARB_MUX_CACHE_EN
        expect_mux("t5", 1, 1);
`endif
        check("t5_cmd", seq_now(), cmd(1'b1, 8'hB1, 8'h43, 8'h00));
        tick_n(TIMEOUT_CYC);
        bus.seq_cmplt = 1'b1;
        bus.seq_rdata = 8'h3C;
        tick();
        bus.seq_cmplt = 1'b0;
        check("t5_valid", 32'(bus.rsp_valid), onehot(1));
        check("t5_err", 32'(bus.rsp_err), 32'd0);
        check("t5_rdata", 32'(bus.rsp_rdata), 32'h3C);
        tick();

        // Reset during CMD_WAIT
        set_req(2, 1'b0, 8'hC2, 8'h50, 8'h11);
        grant("t6", 2);
        expect_mux("t6", 2, 1);
        check("t6_cmd", seq_now(), cmd(1'b0, 8'hC2, 8'h50, 8'h11));
        tick_n(2);
        rstn = 1'b0;
        set_req(2, 1'b1, 8'hC2, 8'h51, 8'h00);
        bus.seq_cmplt = 1'b1;
        bus.seq_rdata = 8'h99;
        tick();
        bus.seq_cmplt = 1'b0;
        check_reset_outputs("t6_rst");
        rstn = 1'b1;
        grant("t6b", 2);
        check("t6b_no_rsp", 32'(bus.rsp_valid), 32'd0);
        expect_mux("t6b", 2, 1);
        check("t6b_cmd", seq_now(), cmd(1'b1, 8'hC2, 8'h51, 8'h00));
        finish_cmd("t6b", 2, 1, 8'h5E);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
